alu: RTL and testbench



---
 rtl/alu_if.sv | 25 ++
 rtl/alu.sv | 90 +++++++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage driver and the ALU.
// The master drives operands and the capture enable; the slave returns the registered result and flags.
interface alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             valid;

  modport master (
    output en, alucontrol, x, y,
    input  result, zero, carry, overflow, valid
  );

  modport slave (
    input  en, alucontrol, x, y,
    output result, zero, carry, overflow, valid
  );
endinterface

// File: rtl/alu.sv
// MIPS execute-stage ALU with a one-cycle registered result and branch/SLT status flags.
// Defining ALU_FLAGS_EN builds the zero/carry/overflow flags; otherwise those outputs are tied to 0.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  logic             sub;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;

  // One shared adder serves ADD, SUB and SLT; subtraction is x + ~y + 1.
  always_comb begin
    sub = (bus.alucontrol == 3'b110) || (bus.alucontrol == 3'b111);
    b   = sub ? ~bus.y : bus.y;
    sum = {1'b0, bus.x} + {1'b0, b} + {{WIDTH{1'b0}}, sub};
    ovf = (bus.x[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != bus.x[WIDTH-1]);
  end

  always_comb begin
    res_d = '0;
    unique case (bus.alucontrol)
      3'b000:  res_d = bus.x & bus.y;
      3'b001:  res_d = bus.x | bus.y;
      3'b010:  res_d = sum[WIDTH-1:0];
      3'b011:  res_d = bus.x ^ bus.y;
      3'b100:  res_d = bus.x & ~bus.y;
      3'b101:  res_d = bus.x | ~bus.y;
      3'b110:  res_d = sum[WIDTH-1:0];
      // Sign of the difference corrected by overflow gives a true signed less-than.
      3'b111:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        result_q <= res_d;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;

`ifdef ALU_FLAGS_EN
  logic arith;
  logic zero_q;
  logic carry_q;
  logic overflow_q;

  assign arith = (bus.alucontrol == 3'b010) || (bus.alucontrol == 3'b110);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.en) begin
      zero_q     <= (res_d == '0);
      carry_q    <= arith & sum[WIDTH];
      overflow_q <= arith & ovf;
    end
  end

  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
`else
  logic unused_carry;
  assign unused_carry = sum[WIDTH];

  assign bus.zero     = 1'b0;
  assign bus.carry    = 1'b0;
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed plus randomised bench for alu; expected results go through a scoreboard queue.
module tb_alu;

`ifdef ALU_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference from arithmetic semantics: wide unsigned sums and signed range checks.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_l;
    longint s;
    sa         = $signed(a);
    sb_l       = $signed(b);
    e.carry    = 1'b0;
    e.overflow = 1'b0;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: begin
        e.result   = a + b;
        e.carry    = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s          = sa + sb_l;
        e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b011: e.result = a ^ b;
      3'b100: e.result = a & ~b;
      3'b101: e.result = a | ~b;
      3'b110: begin
        e.result   = a - b;
        e.carry    = (a >= b);
        s          = sa - sb_l;
        e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: e.result = (sa < sb_l) ? 32'd1 : 32'd0;
    endcase
    e.zero     = FlagsEn & (e.result == 32'd0);
    e.carry    = FlagsEn & e.carry;
    e.overflow = FlagsEn & e.overflow;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic exp_valid);
    check({tag, ".result"}, bus.result, e.result);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
    check({tag, ".carry"}, {31'd0, bus.carry}, {31'd0, e.carry});
    check({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, e.overflow});
    check({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, exp_valid});
  endtask

  // One operation per cycle: drive on the falling edge, compare #1 after the capturing edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.en         = 1'b1;
    bus.alucontrol = op;
    bus.x          = a;
    bus.y          = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e, 1'b1);
      last = e;
    end
  endtask

  initial begin
    exp_t rst_e;
    rst_e.result   = 32'd0;
    rst_e.zero     = FlagsEn;
    rst_e.carry    = 1'b0;
    rst_e.overflow = 1'b0;

    rst_n          = 1'b0;
    bus.en         = 1'b1;
    bus.alucontrol = 3'b110;
    bus.x          = 32'd5;
    bus.y          = 32'd7;
    #2;
    check_outputs("reset", rst_e, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step("sub5_7", 3'b110, 32'd5, 32'd7);
    step("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1);
    step("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1);
    step("slt_m1_1", 3'b111, 32'hFFFF_FFFF, 32'd1);
    step("slt_min_max", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
    step("slt_7_5", 3'b111, 32'd7, 32'd5);
    step("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("or", 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("xor", 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("andn", 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("orn", 3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step("sub_eq", 3'b110, 32'h1234_5678, 32'h1234_5678);
    step("sub_ovf", 3'b110, 32'h8000_0000, 32'd1);

    // Hold: en low with new inputs must leave result and flags untouched.
    @(negedge clk);
    bus.en         = 1'b0;
    bus.alucontrol = 3'b010;
    bus.x          = 32'hDEAD_BEEF;
    bus.y          = 32'h1111_1111;
    @(posedge clk);
    #1;
    check_outputs("hold", last, 1'b0);

    step("after_hold", 3'b010, 32'h7FFF_FFFF, 32'd1);

    // Reset between edges clears outputs without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("mid_reset", rst_e, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_reset_idle", rst_e, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
      step("random", op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
